// File: rtl/reg_file_param_if.sv
// Bus bundle for reg_file_param: read selects, write port, pc/flags inputs,
// clear request, and the registered read/flags/busy outputs.
interface reg_file_param_if #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 16,
    parameter int FLAG_W = 4
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] sel1;
    logic [ADDR_W-1:0] sel2;
    logic [ADDR_W-1:0] wr_sel;
    logic [WIDTH-1:0]  in;
    logic              write_en;
    logic [WIDTH-1:0]  pc;
    logic [FLAG_W-1:0] flags_in;
    logic              flags_we;
    logic              clear_req;
    logic [WIDTH-1:0]  out1;
    logic [WIDTH-1:0]  out2;
    logic [FLAG_W-1:0] flags_out;
    logic              busy;

    modport master (
        output sel1, sel2, wr_sel, in, write_en, pc, flags_in, flags_we, clear_req,
        input  out1, out2, flags_out, busy
    );

    modport slave (
        input  sel1, sel2, wr_sel, in, write_en, pc, flags_in, flags_we, clear_req,
        output out1, out2, flags_out, busy
    );
endinterface

// File: rtl/reg_file_param.sv
// Register file: r0 hardwired zero, r[DEPTH-2] flags, r[DEPTH-1] PC mirror, clear sweep.
// Define REGFILE_BYPASS_EN to forward same-edge writes into the read ports.
module reg_file_param #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 16,
    parameter int FLAG_W = 4
) (
    input logic             clk,
    input logic             rst,
    reg_file_param_if.slave bus
);
    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int TOP_GPR = DEPTH - 3;
    localparam logic [ADDR_W-1:0] FLAG_IDX = ADDR_W'(DEPTH - 2);
    localparam logic [ADDR_W-1:0] PC_IDX   = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t                       state, state_nxt;
    logic [ADDR_W-1:0]            cnt, cnt_nxt;
    logic                         sweep_zero;
    logic                         gpr_we;
    logic [TOP_GPR:1][WIDTH-1:0]  gpr;
    logic [FLAG_W-1:0]            flags, flags_nxt;
    logic [WIDTH-1:0]             pc_q;
    logic [DEPTH-1:0][WIDTH-1:0]  view_old, view_rd;

    assign gpr_we   = bus.write_en && (state == IDLE);
    assign bus.busy = (state == SWEEP);
    assign bus.flags_out = flags;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        sweep_zero = 1'b0;
        case (state)
            IDLE: begin
                if (bus.clear_req) begin
                    state_nxt = SWEEP;
                    cnt_nxt   = ADDR_W'(1);
                end
            end
            SWEEP: begin
                sweep_zero = 1'b1;
                cnt_nxt    = cnt + 1'b1;
                if (cnt == ADDR_W'(TOP_GPR))
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Writes are only accepted in IDLE, so they never collide with sweep zeroing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gpr <= '0;
        end else begin
            for (int k = 1; k <= TOP_GPR; k++) begin
                if (gpr_we && bus.wr_sel == ADDR_W'(k))
                    gpr[k] <= bus.in;
                else if (sweep_zero && cnt == ADDR_W'(k))
                    gpr[k] <= '0;
            end
        end
    end

    // flags_we beats a GPR write aimed at the flags slot.
    always_comb begin
        flags_nxt = flags;
        if (gpr_we && bus.wr_sel == FLAG_IDX)
            flags_nxt = bus.in[FLAG_W-1:0];
        if (bus.flags_we)
            flags_nxt = bus.flags_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flags <= '0;
            pc_q  <= '0;
        end else begin
            flags <= flags_nxt;
            pc_q  <= bus.pc;
        end
    end

    always_comb begin
        view_old = '0;
        for (int k = 1; k <= TOP_GPR; k++)
            view_old[k] = gpr[k];
        view_old[FLAG_IDX] = WIDTH'(flags);
        view_old[PC_IDX]   = pc_q;
    end

`ifdef REGFILE_BYPASS_EN
    // Sweep zeroing is deliberately not forwarded; only architectural writes are.
    always_comb begin
        view_rd = view_old;
        for (int k = 1; k <= TOP_GPR; k++)
            if (gpr_we && bus.wr_sel == ADDR_W'(k))
                view_rd[k] = bus.in;
        view_rd[FLAG_IDX] = WIDTH'(flags_nxt);
        view_rd[PC_IDX]   = bus.pc;
    end
`else
    assign view_rd = view_old;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.out1 <= '0;
            bus.out2 <= '0;
        end else begin
            bus.out1 <= view_rd[bus.sel1];
            bus.out2 <= view_rd[bus.sel2];
        end
    end
endmodule
